// File: rtl/button_reader.sv
// button_reader
//   Reads one raw, bouncy pushbutton pin and produces a debounced level,
//   one-cycle press/release events and a 2-bit press counter used as the
//   colour select by the downstream RGB LED decode.
//
//   Optional: define BUTTON_READER_LONG_PRESS_EN to build the long-hold
//   detector.  When it fires, long_press pulses and sel returns to 0.
//   Without the macro, long_press is tied to 0.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   btn_raw       raw button pin, asynchronous to clk
//   pressed       debounced level, 1 = held
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on an accepted release
//   sel           press count modulo 4
//   long_press    one-cycle pulse after a long hold (0 without the macro)
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int LONG_CYCLES     = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] sel,
  output logic       long_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic IDLE_LVL = (BTN_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED_ST  = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sync_p0, sync_p1;
  logic             act;
  logic             rise, fall;
  logic             long_fire;

  // Stage p0/p1: two-flop synchroniser, reset to the idle pin level so a
  // reset never looks like a press edge by itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= IDLE_LVL;
      sync_p1 <= IDLE_LVL;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign act = (BTN_ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  // Debounce FSM: the counter only runs in the CHK states and is zero on
  // every state entry, so each check starts counting from scratch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      RELEASED:    if (act) state_nxt = PRESS_CHK;
      PRESS_CHK: begin
        if (!act)                 state_nxt = RELEASED;
        else if (cnt == CNT_LAST) state_nxt = PRESSED_ST;
        else                      cnt_nxt   = cnt + 1'b1;
      end
      PRESSED_ST:  if (!act) state_nxt = RELEASE_CHK;
      RELEASE_CHK: begin
        if (act)                  state_nxt = PRESSED_ST;
        else if (cnt == CNT_LAST) state_nxt = RELEASED;
        else                      cnt_nxt   = cnt + 1'b1;
      end
      default:     state_nxt = RELEASED;
    endcase
  end

  assign rise = (state == PRESS_CHK)   && (state_nxt == PRESSED_ST);
  assign fall = (state == RELEASE_CHK) && (state_nxt == RELEASED);

  // Outputs are registered from the next-state decode so they change on the
  // same edge the FSM accepts the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RELEASED;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      sel           <= 2'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pressed       <= (state_nxt == PRESSED_ST) || (state_nxt == RELEASE_CHK);
      press_pulse   <= rise;
      release_pulse <= fall;
      if (long_fire)  sel <= 2'd0;
      else if (rise)  sel <= sel + 2'd1;
    end
  end

`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold;

  // Saturating past HOLD_LAST guarantees a single fire per press.
  assign long_fire = (state == PRESSED_ST) && (hold == HOLD_LAST);

  // The hold count survives a RELEASE_CHK bounce so a shaky hold cannot
  // re-arm the long-press event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= long_fire;
      if (state == PRESSED_ST) begin
        if (hold != HOLD_MAX) hold <= hold + 1'b1;
      end else if (state != RELEASE_CHK) begin
        hold <= '0;
      end
    end
  end
`else
  assign long_fire  = 1'b0;
  assign long_press = 1'b0;
`endif

endmodule
